// File: rtl/i2c_line_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_conditioner
// Purpose  : Synchronises and glitch-filters the raw SCL/SDA pad inputs and
//            derives filtered levels, edge strobes, START/STOP strobes and a
//            bus-busy flag for the downstream I2C slave FSM.
// Revision : 1.0  initial release
// ============================================================================
module i2c_line_conditioner #(
    parameter int SYNC_STAGES = 2,   // synchroniser flops per line (>= 2)
    parameter int FILT_LEN    = 4    // consecutive mismatching clks to accept a level (>= 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);

    // Line index 0 is SCL, line index 1 is SDA.
    logic [1:0] raw_lines;
    logic [1:0] filt_q;      // current filtered level per line
    logic [1:0] filt_d;      // filtered level after this clock edge

    assign raw_lines = {sda_in, scl_in};

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   f_q;
        logic                   f_d;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        // Synchroniser chain; resets to the idle (high) bus level.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_lines[i]};
            end
        end

        // Persistence filter: accept s only after FILT_LEN consecutive mismatching clks.
        always_comb begin
            cnt_d = '0;
            f_d   = f_q;
            if (s != f_q) begin
                if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                    f_d = s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Filter state register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                f_q   <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                f_q   <= f_d;
            end
        end

        assign filt_q[i] = f_q;
        assign filt_d[i] = f_d;
    end

    // Edge and bus-condition decode on the filtered levels. These are computed
    // from the next filtered value so every strobe registers in the same cycle
    // that the filtered level changes.
    logic [1:0] rise_d;
    logic [1:0] fall_d;
    logic       start_d;
    logic       stop_d;
    logic       busy_d;
    logic       busy_q;
    logic       start_q;
    logic       stop_q;
    logic [1:0] rise_q;
    logic [1:0] fall_q;

    // SCL must be high before and after the SDA transition; a simultaneous
    // SCL change disqualifies START/STOP.
    always_comb begin
        rise_d  = filt_d & ~filt_q;
        fall_d  = ~filt_d & filt_q;
        start_d = fall_d[1] & filt_q[0] & filt_d[0];
        stop_d  = rise_d[1] & filt_q[0] & filt_d[0];
        busy_d  = busy_q;
        if (start_q) begin
            busy_d = 1'b1;
        end else if (stop_q) begin
            busy_d = 1'b0;
        end
    end

    // Output strobe and busy-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q  <= '0;
            fall_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
        end
    end

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = rise_q[0];
    assign scl_fall  = fall_q[0];
    assign sda_rise  = rise_q[1];
    assign sda_fall  = fall_q[1];
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign bus_busy  = busy_q;

endmodule
`default_nettype wire
